// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the reorder-buffer entry layout.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // One in-flight instruction awaiting in-order retirement.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  has_dest;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer feeding the architectural register file.
// Dispatch allocates entries in program order, execution units complete
// them by tag out of order, and the oldest completed entry retires one per
// cycle onto the register file write port.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   flush              discard every in-flight entry this cycle
//   alloc_*            dispatch handshake; alloc_tag is the granted entry
//   wb_*               out-of-order result writeback by tag
//   commit_*           register file write port (rd / rd_data / RegWrite)
//   empty, count       occupancy status
module reorder_buffer
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,

    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    input  logic                  alloc_has_dest,
    output logic [TAG_W-1:0]      alloc_tag,

    input  logic                  wb_valid,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic [XLEN-1:0]       wb_data,

    output logic                  commit_valid,
    output logic [REG_ADDR_W-1:0] commit_rd,
    output logic [XLEN-1:0]       commit_rd_data,
    output logic                  commit_reg_write,

    output logic                  empty,
    output logic [TAG_W:0]        count
);

    localparam int unsigned PTR_W = TAG_W + 1;

    rob_entry_t entries [DEPTH];

    // Pointers carry an extra wrap bit to tell full from empty.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             wb_hit;
    rob_entry_t       head_entry;

    assign head_idx   = head[TAG_W-1:0];
    assign tail_idx   = tail[TAG_W-1:0];
    assign full       = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign empty      = (head == tail);
    assign count      = tail - head;
    assign alloc_ready = !full;
    assign alloc_tag  = tail_idx;
    assign alloc_fire = alloc_valid && alloc_ready;
    assign wb_hit     = wb_valid && entries[wb_tag].valid;
    assign head_entry = entries[head_idx];

    // Retire port: driven straight from registered head state, zeroed when idle.
    always_comb begin
        commit_valid     = 1'b0;
        commit_rd        = '0;
        commit_rd_data   = '0;
        commit_reg_write = 1'b0;
        if (rst_n && !flush && head_entry.valid && head_entry.done) begin
            commit_valid     = 1'b1;
            commit_rd        = head_entry.rd;
            commit_rd_data   = head_entry.data;
            commit_reg_write = head_entry.has_dest && (head_entry.rd != '0);
        end
    end

    // Entry and pointer updates. Alloc never targets a valid entry (blocked
    // when full), so wb/alloc/commit never collide on the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
            head <= '0;
            tail <= '0;
        end else begin
            if (wb_hit) begin
                entries[wb_tag].done <= 1'b1;
                entries[wb_tag].data <= wb_data;
            end
            if (alloc_fire) begin
                entries[tail_idx].valid    <= 1'b1;
                entries[tail_idx].done     <= 1'b0;
                entries[tail_idx].has_dest <= alloc_has_dest;
                entries[tail_idx].rd       <= alloc_rd;
                tail                       <= tail + PTR_W'(1);
            end
            if (commit_valid) begin
                entries[head_idx].valid <= 1'b0;
                head                    <= head + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer (DEPTH=8, XLEN=32).
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rd;
    logic        alloc_has_dest;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_rd_data;
    logic        commit_reg_write;
    logic        empty;
    logic [3:0]  count;

    reorder_buffer #(.DEPTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_rd         (alloc_rd),
        .alloc_has_dest   (alloc_has_dest),
        .alloc_tag        (alloc_tag),
        .wb_valid         (wb_valid),
        .wb_tag           (wb_tag),
        .wb_data          (wb_data),
        .commit_valid     (commit_valid),
        .commit_rd        (commit_rd),
        .commit_rd_data   (commit_rd_data),
        .commit_reg_write (commit_reg_write),
        .empty            (empty),
        .count            (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retirement must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (commit_valid === 1'b1) begin
                chk("commit_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("commit_rd", 64'(commit_rd), 64'(mon_e.rd));
                    chk("commit_rd_data", 64'(commit_rd_data), 64'(mon_e.data));
                    chk("commit_reg_write", 64'(commit_reg_write), 64'(mon_e.rw));
                end
            end else begin
                chk("idle_reg_write", 64'(commit_reg_write), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic hd, input int tag, input logic [31:0] data);
        exp_t t;
        alloc_valid    = 1'b1;
        alloc_rd       = rd;
        alloc_has_dest = hd;
        chk("alloc_ready", 64'(alloc_ready), 64'd1);
        chk("alloc_tag", 64'(alloc_tag), 64'(tag));
        t.rd   = rd;
        t.data = data;
        t.rw   = hd && (rd != 5'd0);
        sb.push_back(t);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb(input int tag, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_tag   = 3'(tag);
        wb_data  = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_count(input int target, input int budget, input string name);
        int n = 0;
        while (count !== 4'(target) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(count), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; alloc_has_dest = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;

        // 1: reset
        tick(); tick();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_commit_reg_write", 64'(commit_reg_write), 64'd0);
        rst_n = 1'b1;

        // 2: out-of-order writeback, in-order retirement
        do_alloc(5'd1, 1'b1, 0, 32'h11);
        do_alloc(5'd2, 1'b1, 1, 32'h22);
        do_alloc(5'd3, 1'b1, 2, 32'h33);
        do_wb(2, 32'h33);
        chk("t2_no_early_commit", 64'(commit_valid), 64'd0);
        chk("t2_count3", 64'(count), 64'd3);
        do_wb(0, 32'h11);
        do_wb(1, 32'h22);
        chk("t2_count2", 64'(count), 64'd2);
        tick();
        chk("t2_count1", 64'(count), 64'd1);
        tick();
        chk("t2_count0", 64'(count), 64'd0);

        // 3: fill, partial drain, wrap-around refill
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) do_alloc(5'(8 + i), 1'b1, i, 32'h100 + 32'(i));
        chk("t3_full_ready", 64'(alloc_ready), 64'd0);
        chk("t3_full_count", 64'(count), 64'd8);
        for (int i = 0; i < 3; i++) do_wb(i, 32'h100 + 32'(i));
        wait_count(5, 10, "t3_drain3");
        for (int i = 0; i < 3; i++) do_alloc(5'(16 + i), 1'b1, i, 32'h200 + 32'(i));
        chk("t3_refill_count", 64'(count), 64'd8);
        chk("t3_refill_ready", 64'(alloc_ready), 64'd0);
        for (int i = 3; i < 8; i++) do_wb(i, 32'h100 + 32'(i));
        for (int i = 0; i < 3; i++) do_wb(i, 32'h200 + 32'(i));
        wait_count(0, 30, "t3_drain_all");

        // 4: no destination and x0 destination retire without RegWrite
        do_alloc(5'd5, 1'b0, 3, 32'hAAAA);
        do_alloc(5'd0, 1'b1, 4, 32'hBBBB);
        do_wb(3, 32'hAAAA);
        do_wb(4, 32'hBBBB);
        wait_count(0, 10, "t4_drain");

        // 5: flush with head done, alloc and wb in the same cycle
        for (int i = 0; i < 5; i++) do_alloc(5'(10 + i), 1'b1, (5 + i) % 8, 32'h500 + 32'(i));
        do_wb(7, 32'h502);
        do_wb(5, 32'h500);
        flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd20; alloc_has_dest = 1'b1;
        wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 32'hDEAD;
        sb.delete();
        #1;
        chk("t5_flush_no_commit", 64'(commit_valid), 64'd0);
        chk("t5_flush_ready", 64'(alloc_ready), 64'd1);
        chk("t5_flush_tag", 64'(alloc_tag), 64'd2);
        tick();
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_count", 64'(count), 64'd0);
        do_alloc(5'd21, 1'b1, 0, 32'h600);
        do_wb(0, 32'h600);
        wait_count(0, 10, "t5_drain");

        // 6: full with head done; blocked alloc, then reuse of freed slot
        for (int i = 0; i < 8; i++) do_alloc(5'(1 + i), 1'b1, (1 + i) % 8, 32'h700 + 32'(i));
        chk("t6_full_count", 64'(count), 64'd8);
        do_wb(1, 32'h700);
        alloc_valid = 1'b1; alloc_rd = 5'd30; alloc_has_dest = 1'b1;
        #1;
        chk("t6_blocked_ready", 64'(alloc_ready), 64'd0);
        chk("t6_head_commits", 64'(commit_valid), 64'd1);
        tick();
        alloc_valid = 1'b0;
        chk("t6_count7", 64'(count), 64'd7);
        chk("t6_ready_again", 64'(alloc_ready), 64'd1);
        chk("t6_freed_tag", 64'(alloc_tag), 64'd1);
        // alloc into freed slot while a stale wb targets the same tag
        wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 32'hBAD;
        do_alloc(5'd30, 1'b1, 1, 32'h7FF);
        wb_valid = 1'b0;
        chk("t6_count8", 64'(count), 64'd8);
        for (int i = 1; i < 8; i++) do_wb((1 + i) % 8, 32'h700 + 32'(i));
        wait_count(1, 20, "t6_drain_to_one");
        tick();
        chk("t6_stale_wb_ignored", 64'(commit_valid), 64'd0);
        chk("t6_count1", 64'(count), 64'd1);
        do_wb(1, 32'h7FF);
        wait_count(0, 10, "t6_drain");

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
